// File: rtl/mig_app_pkg.sv
// Shared command encodings for the MIG app-interface responder.
package mig_app_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_WRITE = 3'b000;
    localparam cmd_t CMD_READ  = 3'b001;

endpackage

// File: rtl/mig_app_responder_if.sv
// MIG user (app_*) interface bundle: master = user logic, slave = memory-side responder.
interface mig_app_responder_if
    import mig_app_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
) ();

    logic                      init_calib_complete;
    logic                      app_en;
    cmd_t                      app_cmd;
    logic [ADDR_WIDTH-1:0]     app_addr;
    logic                      app_rdy;
    logic                      app_wdf_wren;
    logic                      app_wdf_end;
    logic [DATA_WIDTH/8-1:0]   app_wdf_mask;
    logic [DATA_WIDTH-1:0]     app_wdf_data;
    logic                      app_wdf_rdy;
    logic [DATA_WIDTH-1:0]     app_rd_data;
    logic                      app_rd_data_valid;

    modport master (
        input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_mask, app_wdf_data
    );

    modport slave (
        output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_mask, app_wdf_data
    );

endinterface

// File: rtl/mig_wdf_fifo.sv
// Synchronous write-data FIFO holding data plus byte mask; DEPTH must be a power of 2 (>= 2).
module mig_wdf_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [DATA_WIDTH-1:0]   i_push_data,
    input  logic [DATA_WIDTH/8-1:0] i_push_mask,
    input  logic                    i_pop,
    output logic [DATA_WIDTH-1:0]   o_pop_data,
    output logic [DATA_WIDTH/8-1:0] o_pop_mask,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int PW     = $clog2(DEPTH);
    localparam int MASK_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [MASK_W-1:0]     r_mask [DEPTH];
    logic [PW:0]           r_wr_ptr;
    logic [PW:0]           r_rd_ptr;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_pop_data = r_data[r_rd_ptr[PW-1:0]];
    assign o_pop_mask = r_mask[r_rd_ptr[PW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_data[r_wr_ptr[PW-1:0]] <= i_push_data;
            r_mask[r_wr_ptr[PW-1:0]] <= i_push_mask;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mig_app_responder.sv
// Behavioural MIG app-interface responder: calibration delay, single-beat writes via WDF, fixed-latency reads.
// Optional controller backpressure on app_rdy when MIG_RESP_THROTTLE_EN is defined.
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int CAL_CYCLES = 16,
    parameter int RD_LATENCY = 4,
    parameter int WDF_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    mig_app_responder_if.slave     app
);

    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int CW     = $clog2(CAL_CYCLES + 1);

    logic [CW-1:0]         r_cal_cnt;
    logic                  r_calib;
    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [DATA_WIDTH-1:0] r_pipe_data [RD_LATENCY];

    logic                  w_throttle;
    logic                  w_app_rdy;
    logic                  w_wdf_rdy;
    logic                  w_cmd_acc;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_commit;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_pop_data;
    logic [MASK_W-1:0]     w_pop_mask;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_unused_wdf_end;

    // Single-beat bursts only, so the last-beat flag carries no information.
    assign w_unused_wdf_end = app.app_wdf_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cal_cnt <= CW'(CAL_CYCLES - 1);
            r_calib   <= 1'b0;
        end else if (!r_calib) begin
            if (r_cal_cnt == '0) r_calib   <= 1'b1;
            else                 r_cal_cnt <= r_cal_cnt - 1'b1;
        end
    end

`ifdef MIG_RESP_THROTTLE_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_lfsr <= 16'hACE1;
        else      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_throttle = (r_lfsr[1:0] == 2'b00);
`else
    assign w_throttle = 1'b0;
`endif

    // Holding off new commands while a write waits for data keeps commits strictly in order.
    assign w_app_rdy = r_calib & ~r_pend & ~w_throttle;
    assign w_wdf_rdy = r_calib & ~w_fifo_full;
    assign w_cmd_acc = app.app_en & w_app_rdy;
    assign w_wr_acc  = w_cmd_acc & (app.app_cmd == CMD_WRITE);
    assign w_rd_acc  = w_cmd_acc & (app.app_cmd == CMD_READ);
    assign w_commit  = r_pend & ~w_fifo_empty;

    mig_wdf_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (WDF_DEPTH)
    ) u_wdf_fifo (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_push      (app.app_wdf_wren & w_wdf_rdy),
        .i_push_data (app.app_wdf_data),
        .i_push_mask (app.app_wdf_mask),
        .i_pop       (w_commit),
        .o_pop_data  (w_pop_data),
        .o_pop_mask  (w_pop_mask),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
        end else if (w_commit) begin
            r_pend <= 1'b0;
        end else if (w_wr_acc) begin
            r_pend      <= 1'b1;
            r_pend_addr <= app.app_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!w_pop_mask[b]) r_mem[r_pend_addr][8*b +: 8] <= w_pop_data[8*b +: 8];
            end
        end
    end

    assign w_rd_word = r_mem[app.app_addr];

    // Each stage only loads when its input is valid, so the last stage holds the previous read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) r_pipe_data[i] <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_acc;
            if (w_rd_acc) r_pipe_data[0] <= w_rd_word;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                if (r_pipe_vld[i-1]) r_pipe_data[i] <= r_pipe_data[i-1];
            end
        end
    end

    assign app.init_calib_complete = r_calib;
    assign app.app_rdy             = w_app_rdy;
    assign app.app_wdf_rdy         = w_wdf_rdy;
    assign app.app_rd_data         = r_pipe_data[RD_LATENCY-1];
    assign app.app_rd_data_valid   = r_pipe_vld[RD_LATENCY-1];

endmodule

// File: tb/tb_mig_app_responder.sv
// Bench for mig_app_responder: directed scenarios plus random traffic against a transaction-level memory model.
module tb_mig_app_responder;
    import mig_app_pkg::*;

    localparam int DW  = 64;
    localparam int AW  = 6;
    localparam int LAT = 4;
    localparam int CAL = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mig_app_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) app_if ();

    mig_app_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CAL_CYCLES (CAL),
        .RD_LATENCY (LAT),
        .WDF_DEPTH  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .app (app_if)
    );

    typedef struct { logic [63:0] d; logic [7:0] m; } beat_t;
    typedef struct { int due; logic [63:0] d; } rexp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_valid  = 0;
    logic [63:0] last_rd  = '0;
    bit          last_cmd_acc;
    bit          last_wdf_acc;
    logic [63:0] m_mem [64];
    beat_t       m_beats [$];
    int          m_waddr [$];
    rexp_t       m_rexp [$];
    int          vcyc_q [$];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    endtask

    // Pair write commands with data beats in arrival order and apply unmasked bytes.
    function automatic void model_drain();
        while (m_beats.size() > 0 && m_waddr.size() > 0) begin
            beat_t bt;
            int    a;
            bt = m_beats.pop_front();
            a  = m_waddr.pop_front();
            for (int b = 0; b < 8; b++)
                if (!bt.m[b]) m_mem[a][8*b +: 8] = bt.d[8*b +: 8];
        end
    endfunction

    task automatic tick();
        bit    c_acc, w_acc;
        cmd_t  c;
        int    a;
        beat_t bt;
        bit    exp_v;
        c_acc = app_if.app_en && app_if.app_rdy && rst;
        w_acc = app_if.app_wdf_wren && app_if.app_wdf_rdy && rst;
        c     = app_if.app_cmd;
        a     = int'(app_if.app_addr);
        bt.d  = app_if.app_wdf_data;
        bt.m  = app_if.app_wdf_mask;
        @(posedge clk);
        #1;
        cyc++;
        last_cmd_acc = c_acc;
        last_wdf_acc = w_acc;
        if (w_acc) m_beats.push_back(bt);
        if (c_acc && c == CMD_WRITE) m_waddr.push_back(a);
        model_drain();
        if (c_acc && c == CMD_READ) m_rexp.push_back('{due: cyc - 1 + LAT, d: m_mem[a]});
        exp_v = (m_rexp.size() > 0) && (m_rexp[0].due == cyc);
        if (app_if.app_rd_data_valid || exp_v) begin
            check_val("rd_valid", 64'(app_if.app_rd_data_valid), 64'(exp_v));
            if (app_if.app_rd_data_valid) begin
                n_valid++;
                vcyc_q.push_back(cyc);
                last_rd = app_if.app_rd_data;
            end
            if (exp_v) begin
                if (app_if.app_rd_data_valid) check_val("rd_data", app_if.app_rd_data, m_rexp[0].d);
                void'(m_rexp.pop_front());
            end
        end
    endtask

    task automatic send_cmd(input cmd_t c, input int a);
        app_if.app_en   = 1'b1;
        app_if.app_cmd  = c;
        app_if.app_addr = AW'(a);
        last_cmd_acc    = 1'b0;
        for (int i = 0; i < 200 && !last_cmd_acc; i++) tick();
        check_val("cmd_accept", 64'(last_cmd_acc), 64'd1);
        app_if.app_en = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] m);
        app_if.app_wdf_wren = 1'b1;
        app_if.app_wdf_data = d;
        app_if.app_wdf_mask = m;
        last_wdf_acc        = 1'b0;
        for (int i = 0; i < 200 && !last_wdf_acc; i++) tick();
        check_val("wdf_accept", 64'(last_wdf_acc), 64'd1);
        app_if.app_wdf_wren = 1'b0;
    endtask

    task automatic write_word(input int a, input logic [63:0] d, input logic [7:0] m);
        bit c_done = 1'b0;
        bit w_done = 1'b0;
        app_if.app_en       = 1'b1;
        app_if.app_cmd      = CMD_WRITE;
        app_if.app_addr     = AW'(a);
        app_if.app_wdf_wren = 1'b1;
        app_if.app_wdf_data = d;
        app_if.app_wdf_mask = m;
        for (int i = 0; i < 200 && !(c_done && w_done); i++) begin
            tick();
            if (last_cmd_acc) begin c_done = 1'b1; app_if.app_en = 1'b0; end
            if (last_wdf_acc) begin w_done = 1'b1; app_if.app_wdf_wren = 1'b0; end
        end
        check_val("wr_accept", 64'({c_done, w_done}), 64'd3);
        app_if.app_en       = 1'b0;
        app_if.app_wdf_wren = 1'b0;
        tick();
    endtask

    task automatic drain_reads();
        for (int i = 0; i < 50 && m_rexp.size() > 0; i++) tick();
        check_val("rd_drain", 64'(m_rexp.size()), 64'd0);
    endtask

    task automatic read_word(input int a, output int acc_cyc);
        send_cmd(CMD_READ, a);
        acc_cyc = cyc - 1;
        drain_reads();
    endtask

    task automatic assert_reset();
        rst                 = 1'b0;
        app_if.app_en       = 1'b0;
        app_if.app_wdf_wren = 1'b0;
        m_rexp.delete();
        m_beats.delete();
        m_waddr.delete();
    endtask

    task automatic check_calib_rise(input string tag);
        for (int n = 1; n <= CAL + 1; n++) begin
            tick();
            check_val({tag, "_calib"}, 64'(app_if.init_calib_complete), 64'(n >= CAL));
            check_val({tag, "_wdf_rdy"}, 64'(app_if.app_wdf_rdy), 64'(n >= CAL));
`ifndef MIG_RESP_THROTTLE_EN
            check_val({tag, "_app_rdy"}, 64'(app_if.app_rdy), 64'(n >= CAL));
`else
            if (n < CAL) check_val({tag, "_app_rdy"}, 64'(app_if.app_rdy), 64'd0);
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        int          acc_c;
        int          got;
        logic [63:0] t5_d [4];
        int          ops, wr_sent, bt_sent;

        app_if.app_en       = 1'b0;
        app_if.app_cmd      = CMD_WRITE;
        app_if.app_addr     = '0;
        app_if.app_wdf_wren = 1'b0;
        app_if.app_wdf_end  = 1'b1;
        app_if.app_wdf_mask = '0;
        app_if.app_wdf_data = '0;

        // Reset state and calibration rise
        assert_reset();
        repeat (3) tick();
        check_val("rst_calib",   64'(app_if.init_calib_complete), 64'd0);
        check_val("rst_app_rdy", 64'(app_if.app_rdy), 64'd0);
        check_val("rst_wdf_rdy", 64'(app_if.app_wdf_rdy), 64'd0);
        check_val("rst_valid",   64'(app_if.app_rd_data_valid), 64'd0);
        check_val("rst_rd_data", app_if.app_rd_data, 64'd0);
        rst = 1'b1;
        check_calib_rise("cal");

        // Full write then read with latency check
        write_word(5, 64'h1122334455667788, 8'h00);
        read_word(5, acc_c);
        check_val("t2_data", last_rd, 64'h1122334455667788);
        check_val("t2_latency", 64'(vcyc_q[$] - acc_c), 64'(LAT));

        // Partial byte mask over existing word
        write_word(5, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        read_word(5, acc_c);
        check_val("t3_data", last_rd, 64'hFFFFFFFF55667788);

        // Command before data: app_rdy held low until commit
        send_cmd(CMD_WRITE, 9);
        for (int i = 0; i < 3; i++) begin
            check_val("t4_rdy_wait", 64'(app_if.app_rdy), 64'd0);
            tick();
        end
        send_beat(64'hA5A5_0123_4567_5A5A, 8'h00);
        check_val("t4_rdy_precommit", 64'(app_if.app_rdy), 64'd0);
        tick();
`ifndef MIG_RESP_THROTTLE_EN
        check_val("t4_rdy_after", 64'(app_if.app_rdy), 64'd1);
`endif
        read_word(9, acc_c);
        check_val("t4_data", last_rd, 64'hA5A5_0123_4567_5A5A);

        // Fill WDF without commands, drain with writes, then back-to-back reads
        for (int i = 0; i < 4; i++) t5_d[i] = {$urandom(), $urandom()};
        got = 0;
        app_if.app_wdf_wren = 1'b1;
        app_if.app_wdf_mask = 8'h00;
        app_if.app_wdf_data = t5_d[0];
        for (int i = 0; i < 100 && got < 4; i++) begin
            tick();
            if (last_wdf_acc) begin
                got++;
                if (got < 4) app_if.app_wdf_data = t5_d[got];
            end
        end
        app_if.app_wdf_wren = 1'b0;
        check_val("t5_beats", 64'(got), 64'd4);
        check_val("t5_wdf_full", 64'(app_if.app_wdf_rdy), 64'd0);
        tick();
        check_val("t5_wdf_full_hold", 64'(app_if.app_wdf_rdy), 64'd0);
        for (int a = 0; a < 4; a++) send_cmd(CMD_WRITE, a);
        tick();
        check_val("t5_wdf_drained", 64'(app_if.app_wdf_rdy), 64'd1);
        vcyc_q.delete();
        got = 0;
        app_if.app_en   = 1'b1;
        app_if.app_cmd  = CMD_READ;
        app_if.app_addr = '0;
        for (int i = 0; i < 100 && got < 4; i++) begin
            tick();
            if (last_cmd_acc) begin
                got++;
                app_if.app_addr = AW'(got);
            end
        end
        app_if.app_en = 1'b0;
        drain_reads();
        check_val("t5_valid_cnt", 64'(vcyc_q.size()), 64'd4);
        check_val("t5_last_data", last_rd, t5_d[3]);
`ifndef MIG_RESP_THROTTLE_EN
        if (vcyc_q.size() == 4) check_val("t5_consecutive", 64'(vcyc_q[3] - vcyc_q[0]), 64'd3);
`endif

        // Reset with two reads in flight
        got = 0;
        app_if.app_en   = 1'b1;
        app_if.app_cmd  = CMD_READ;
        app_if.app_addr = '0;
        for (int i = 0; i < 100 && got < 2; i++) begin
            tick();
            if (last_cmd_acc) begin
                got++;
                app_if.app_addr = AW'(got);
            end
        end
        check_val("t6_reads_issued", 64'(got), 64'd2);
        assert_reset();
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            check_val("t6_no_valid", 64'(app_if.app_rd_data_valid), 64'd0);
        end
        check_val("t6_rd_data_rst", app_if.app_rd_data, 64'd0);
        rst = 1'b1;
        check_calib_rise("recal");

        // Random traffic; array contents survive reset, so re-seed a known region first
        for (int a = 0; a < 16; a++) write_word(a, {$urandom(), $urandom()}, 8'h00);
        ops = 0; wr_sent = 0; bt_sent = 0;
        for (int i = 0; i < 6000; i++) begin
            if (ops >= 100 && !app_if.app_en && !app_if.app_wdf_wren &&
                m_rexp.size() == 0 && m_waddr.size() == 0) break;
            if (!app_if.app_en && ops < 100 && $urandom_range(0, 3) != 0) begin
                int k;
                k = int'($urandom_range(0, 9));
                app_if.app_en   = 1'b1;
                app_if.app_addr = AW'($urandom_range(0, 15));
                if (k < 4) begin
                    app_if.app_cmd = CMD_WRITE;
                    wr_sent++;
                end else if (k < 9) begin
                    app_if.app_cmd = CMD_READ;
                end else begin
                    app_if.app_cmd = cmd_t'($urandom_range(2, 7));
                end
                ops++;
            end
            if (!app_if.app_wdf_wren && bt_sent < wr_sent + 2 && $urandom_range(0, 1) == 1) begin
                app_if.app_wdf_wren = 1'b1;
                app_if.app_wdf_data = {$urandom(), $urandom()};
                app_if.app_wdf_mask = 8'($urandom_range(0, 255));
                bt_sent++;
            end
            tick();
            if (last_cmd_acc) app_if.app_en = 1'b0;
            if (last_wdf_acc) app_if.app_wdf_wren = 1'b0;
        end
        check_val("rand_ops_done", 64'(ops), 64'd100);
        check_val("rand_cmd_idle", 64'(app_if.app_en), 64'd0);
        check_val("rand_rd_done", 64'(m_rexp.size()), 64'd0);
        check_val("rand_wr_done", 64'(m_waddr.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
